branch_unit_rv32i: RTL

Parametrised successor to the combinational branch resolver. It resolves RV32I conditional branches in EX and predicts fetch-stage branches with a direct-mapped table of 2-bit saturating counters (BHT). Outputs are a registered one-cycle redirect/flush and saturating performance counters. It sits between IF (prediction lookup) and EX (resolution), and drives the PC mux and the pipeline flush.

---
 rtl/branch_unit_rv32i.sv | 110 +++++++++++
 1 files changed

// File: rtl/branch_unit_rv32i.sv
// RV32I conditional-branch resolver with a direct-mapped 2-bit BHT predictor,
// a registered one-cycle redirect pulse and saturating performance counters.
module branch_unit_rv32i #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  fetch_pc,
  output logic             pred_taken,
  input  logic             ex_valid,
  input  logic             cu_branch,
  input  logic [2:0]       cu_branchtype,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_pc_plus4,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  in1,
  input  logic [XLEN-1:0]  in2,
  output logic             ex_taken,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  localparam logic [2:0] BT_BEQ  = 3'b000;
  localparam logic [2:0] BT_BGE  = 3'b001;
  localparam logic [2:0] BT_BGEU = 3'b010;
  localparam logic [2:0] BT_BLT  = 3'b011;
  localparam logic [2:0] BT_BLTU = 3'b100;
  localparam logic [2:0] BT_BNE  = 3'b101;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] ex_idx;
  logic             res;
  logic             legal;
  logic             cond;
  logic             mis;
  logic             unused_pc_bits;

  assign fetch_idx = fetch_pc[IDX_W+1:2];
  assign ex_idx    = ex_pc[IDX_W+1:2];
  assign unused_pc_bits = ^{fetch_pc[1:0], fetch_pc[XLEN-1:IDX_W+2],
                            ex_pc[1:0], ex_pc[XLEN-1:IDX_W+2]};

  // Lookup reads the array before this cycle's update lands (read-before-write).
  assign pred_taken = bht[fetch_idx][1];

  // An EX instruction is resolved only when ex_valid and cu_branch are both
  // high in the same cycle; there is no back-pressure, this block always accepts.
  assign res = ex_valid & cu_branch;

  always_comb begin
    cond  = 1'b0;
    legal = 1'b1;
    case (cu_branchtype)
      BT_BEQ:  cond = (in1 == in2);
      BT_BNE:  cond = (in1 != in2);
      BT_BGE:  cond = ($signed(in1) >= $signed(in2));
      BT_BLT:  cond = ($signed(in1) <  $signed(in2));
      BT_BGEU: cond = (in1 >= in2);
      BT_BLTU: cond = (in1 <  in2);
      default: legal = 1'b0;
    endcase
  end

  assign ex_taken = res & legal & cond;
  assign mis      = res & (ex_taken != ex_pred_taken);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (res && legal) begin
      if (ex_taken) begin
        if (bht[ex_idx] != 2'b11) bht[ex_idx] <= bht[ex_idx] + 2'b01;
      end else begin
        if (bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'b01;
      end
    end
  end

  // redirect_pc keeps its last value between redirects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      redirect <= mis;
      if (mis) redirect_pc <= ex_taken ? ex_target : ex_pc_plus4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count  <= '0;
      mispred_count <= '0;
    end else begin
      if (res && (branch_count != '1))  branch_count  <= branch_count + CNT_ONE;
      if (mis && (mispred_count != '1)) mispred_count <= mispred_count + CNT_ONE;
    end
  end

endmodule
